// File: rtl/sap_ctrl_seq_pkg.sv
// sap_ctrl_seq_pkg: shared definitions for the SAP controller-sequencer.
// Holds the opcode constants, the one-hot T-state encodings, the control-word
// layout and its idle value. Optional build macro: SAP_CTRL_SINGLE_STEP_EN.
package sap_ctrl_seq_pkg;

    // Opcode field width (IR upper nibble) and number of T-states (fixed at 6).
    localparam int OPCODE_W = 4;
    localparam int NUM_T    = 6;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [NUM_T-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    typedef struct packed {
        logic pc_inc;
        logic pc_oe;
        logic low_mar_i_en;
        logic low_ram_oe;
        logic low_ir_i_en;
        logic low_ir_oe;
        logic low_a_i_en;
        logic a_oe;
        logic alu_sub;
        logic alu_oe;
        logic low_b_i_en;
        logic low_out_i_en;
    } ctrl_word_t;

    // Nothing drives the bus and nothing loads: active-high 0, active-low 1.
    localparam ctrl_word_t CTRL_IDLE = '{
        pc_inc:       1'b0,
        pc_oe:        1'b0,
        low_mar_i_en: 1'b1,
        low_ram_oe:   1'b1,
        low_ir_i_en:  1'b1,
        low_ir_oe:    1'b1,
        low_a_i_en:   1'b1,
        a_oe:         1'b0,
        alu_sub:      1'b0,
        alu_oe:       1'b0,
        low_b_i_en:   1'b1,
        low_out_i_en: 1'b1
    };

endpackage

// File: rtl/sap_ctrl_seq_if.sv
// sap_ctrl_seq_if: opcode input plus every control line the sequencer drives
// into the SAP datapath. The controller is the master; the datapath is the slave.
interface sap_ctrl_seq_if import sap_ctrl_seq_pkg::*; ();

    logic [OPCODE_W-1:0] opcode;
    logic [NUM_T-1:0]    t_state;
    logic                halted;
    logic                pc_inc;
    logic                pc_oe;
    logic                low_mar_i_en;
    logic                low_ram_oe;
    logic                low_ir_i_en;
    logic                low_ir_oe;
    logic                low_a_i_en;
    logic                a_oe;
    logic                alu_sub;
    logic                alu_oe;
    logic                low_b_i_en;
    logic                low_out_i_en;

    modport master (
        input  opcode,
        output t_state, halted, pc_inc, pc_oe, low_mar_i_en, low_ram_oe,
               low_ir_i_en, low_ir_oe, low_a_i_en, a_oe, alu_sub, alu_oe,
               low_b_i_en, low_out_i_en
    );

    modport slave (
        output opcode,
        input  t_state, halted, pc_inc, pc_oe, low_mar_i_en, low_ram_oe,
               low_ir_i_en, low_ir_oe, low_a_i_en, a_oe, alu_sub, alu_oe,
               low_b_i_en, low_out_i_en
    );

endinterface

// File: rtl/sap_ctrl_seq_ring_counter_6.sv
// ring_counter_6: six-bit one-hot ring, synchronous reset to T1,
// rotates left by one position on each clock where advance is high.
module ring_counter_6 (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [5:0] state
);

    logic [5:0] state_q;
    logic [5:0] state_d;

    // Next ring position: rotate left when advancing, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = {state_q[4:0], state_q[5]};
        end
    end

    // Ring register; reset parks it at T1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= 6'b000001;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// sap_ctrl_seq: SAP controller-sequencer. A one-hot ring steps T1..T6, the
// opcode is decoded in T4..T6, and a sticky halt flag freezes the ring at T4.
// Optional build macro SAP_CTRL_SINGLE_STEP_EN adds a 'step' input that gates
// every ring advance and halt capture.
module sap_ctrl_seq
    import sap_ctrl_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
`ifdef SAP_CTRL_SINGLE_STEP_EN
    input  logic step,
`endif
    sap_ctrl_seq_if.master bus
);

    logic       step_ok;
    logic [5:0] t_state;
    logic       hlt_now;
    logic       advance;
    logic       halted_q;
    logic       halted_d;
    ctrl_word_t cw;

`ifdef SAP_CTRL_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    ring_counter_6 u_ring (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .state   (t_state)
    );

    // HLT in T4 stops the ring on the same edge that sets the halt flag.
    always_comb begin
        hlt_now  = (t_state == T4) && (bus.opcode == OP_HLT) && !halted_q;
        advance  = step_ok && !halted_q && !hlt_now;
        halted_d = halted_q || (step_ok && hlt_now);
    end

    // Sticky halt flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Control-word decode from T-state and opcode; idle whenever halted.
    always_comb begin
        cw = CTRL_IDLE;
        if (!halted_q) begin
            case (t_state)
                T1: begin
                    cw.pc_oe        = 1'b1;
                    cw.low_mar_i_en = 1'b0;
                end
                T2: begin
                    cw.pc_inc = 1'b1;
                end
                T3: begin
                    cw.low_ram_oe  = 1'b0;
                    cw.low_ir_i_en = 1'b0;
                end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw.low_ir_oe    = 1'b0;
                            cw.low_mar_i_en = 1'b0;
                        end
                        OP_OUT: begin
                            cw.a_oe         = 1'b1;
                            cw.low_out_i_en = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            cw.low_ram_oe = 1'b0;
                            cw.low_a_i_en = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.low_ram_oe = 1'b0;
                            cw.low_b_i_en = 1'b0;
                            cw.alu_sub    = (bus.opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (bus.opcode)
                        OP_ADD, OP_SUB: begin
                            cw.alu_oe     = 1'b1;
                            cw.low_a_i_en = 1'b0;
                            cw.alu_sub    = (bus.opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.t_state      = t_state;
    assign bus.halted       = halted_q;
    assign bus.pc_inc       = cw.pc_inc;
    assign bus.pc_oe        = cw.pc_oe;
    assign bus.low_mar_i_en = cw.low_mar_i_en;
    assign bus.low_ram_oe   = cw.low_ram_oe;
    assign bus.low_ir_i_en  = cw.low_ir_i_en;
    assign bus.low_ir_oe    = cw.low_ir_oe;
    assign bus.low_a_i_en   = cw.low_a_i_en;
    assign bus.a_oe         = cw.a_oe;
    assign bus.alu_sub      = cw.alu_sub;
    assign bus.alu_oe       = cw.alu_oe;
    assign bus.low_b_i_en   = cw.low_b_i_en;
    assign bus.low_out_i_en = cw.low_out_i_en;

    // At most one bus driver may be enabled in any state.
    bus_exclusive: assert property (@(posedge clk) disable iff (reset)
        $onehot0({cw.pc_oe, ~cw.low_ram_oe, ~cw.low_ir_oe, cw.a_oe, cw.alu_oe}));

endmodule
